// File: rtl/dff_bank_arbiter.sv
// Round-robin sequencer that is the sole writer of a shared WIDTH-bit q/qbar
// register: grant one requester, capture its data, then stay busy for HOLD cycles.
module dff_bank_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int HOLD  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*WIDTH-1:0]    din,
  input  logic                     clr,
  output logic [NREQ-1:0]          gnt,
  output logic [WIDTH-1:0]         q,
  output logic [WIDTH-1:0]         qbar,
  output logic [$clog2(NREQ)-1:0]  owner,
  output logic                     busy
);

  localparam int IW = $clog2(NREQ);
  localparam int EW = IW + 1;
  localparam logic [3:0] HOLD_INIT = 4'(HOLD);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_HOLD
  } state_t;

  state_t           state_reg;
  logic [IW-1:0]    ptr_reg;
  logic [IW-1:0]    win_reg;
  logic [3:0]       cnt_reg;
  logic             clr_pend_reg;

  logic [WIDTH-1:0] din_arr [NREQ];
  logic [IW-1:0]    winner_next;
  logic [EW-1:0]    scan_idx;
  logic             scan_found;
  logic             any_req;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_din
      assign din_arr[gi] = din[gi*WIDTH +: WIDTH];
    end
  endgenerate

  assign any_req = |req;

  // Scan from the slot after the last owner, wrapping, and keep the first hit.
  always_comb begin
    winner_next = ptr_reg;
    scan_found  = 1'b0;
    scan_idx    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      scan_idx = EW'(ptr_reg) + EW'(k);
      if (scan_idx >= EW'(NREQ)) begin
        scan_idx = scan_idx - EW'(NREQ);
      end
      if (!scan_found && req[scan_idx[IW-1:0]]) begin
        scan_found  = 1'b1;
        winner_next = scan_idx[IW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= S_IDLE;
      gnt          <= '0;
      q            <= '0;
      qbar         <= '1;
      owner        <= '0;
      busy         <= 1'b0;
      ptr_reg      <= IW'(NREQ - 1);
      win_reg      <= '0;
      cnt_reg      <= '0;
      clr_pend_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          // A clear (fresh or deferred) takes the whole IDLE cycle; no grant alongside it.
          if (clr || clr_pend_reg) begin
            q            <= '0;
            qbar         <= '1;
            clr_pend_reg <= 1'b0;
          end else if (any_req) begin
            gnt       <= NREQ'(1) << winner_next;
            win_reg   <= winner_next;
            busy      <= 1'b1;
            state_reg <= S_CAPTURE;
          end
        end

        S_CAPTURE: begin
          q       <= din_arr[win_reg];
          qbar    <= ~din_arr[win_reg];
          owner   <= win_reg;
          ptr_reg <= win_reg;
          gnt     <= '0;
          if (clr) begin
            clr_pend_reg <= 1'b1;
          end
          if (HOLD == 0) begin
            busy      <= 1'b0;
            state_reg <= S_IDLE;
          end else begin
            cnt_reg   <= HOLD_INIT;
            state_reg <= S_HOLD;
          end
        end

        S_HOLD: begin
          if (clr) begin
            clr_pend_reg <= 1'b1;
          end
          if (cnt_reg == 4'd1) begin
            busy      <= 1'b0;
            state_reg <= S_IDLE;
          end
          cnt_reg <= cnt_reg - 4'd1;
        end

        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Scoreboard bench for dff_bank_arbiter: directed scenarios plus random traffic
// checked against a transaction-level timeline model of the arbiter.
module tb_dff_bank_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int HOLD  = 2;

  typedef struct {
    logic [3:0] g;
    logic [7:0] d;
    int         o;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] din;
  logic        clr;
  logic [3:0]  gnt;
  logic [7:0]  q;
  logic [7:0]  qbar;
  logic [1:0]  owner;
  logic        busy;

  logic [3:0]  zreq;
  logic [31:0] zdin;
  logic        zclr;
  logic [3:0]  zgnt;
  logic [7:0]  zq;
  logic [7:0]  zqbar;
  logic [1:0]  zowner;
  logic        zbusy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit mon_en  = 1'b0;

  // Timeline model: the arbiter may act in IDLE at edge t when t >= m_free.
  int         m_ptr;
  int         m_free;
  int         m_cap_at;
  int         m_cap_idx;
  int         m_owner;
  bit         m_pend;
  logic [7:0] m_q;
  exp_t       sb[$];

  int          glog[$];
  int          gcyc[$];
  int          busy_cycles = 0;
  logic [31:0] z_ghist = '0;
  logic [31:0] z_bhist = '0;

  dff_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .HOLD(HOLD)) dut (
    .clk(clk), .rst(rst), .req(req), .din(din), .clr(clr),
    .gnt(gnt), .q(q), .qbar(qbar), .owner(owner), .busy(busy)
  );

  dff_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .HOLD(0)) dut_h0 (
    .clk(clk), .rst(rst), .req(zreq), .din(zdin), .clr(zclr),
    .gnt(zgnt), .q(zq), .qbar(zqbar), .owner(zowner), .busy(zbusy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int rr_pick(input int ptr, input logic [3:0] r);
    for (int k = 1; k <= NREQ; k++) begin
      if (r[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr     = NREQ - 1;
    m_free    = 0;
    m_cap_at  = -1;
    m_cap_idx = 0;
    m_owner   = 0;
    m_pend    = 1'b0;
    m_q       = 8'h00;
    sb.delete();
  endtask

  task automatic model_step();
    logic [7:0] d;
    if (m_cap_at == cyc) begin
      d       = din[m_cap_idx*8 +: 8];
      m_q     = d;
      m_owner = m_cap_idx;
      m_ptr   = m_cap_idx;
      sb.push_back('{g: 4'(1 << m_cap_idx), d: d, o: m_cap_idx});
      m_cap_at = -1;
    end
    if (cyc >= m_free) begin
      if (clr || m_pend) begin
        m_q    = 8'h00;
        m_pend = 1'b0;
      end else if (req != 4'b0000) begin
        m_cap_idx = rr_pick(m_ptr, req);
        m_cap_at  = cyc + 1;
        m_free    = cyc + 2 + HOLD;
      end
    end else if (clr) begin
      m_pend = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    if (rst) model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((cyc + 1 < m_free || m_cap_at >= 0 || m_pend) && n < 50) begin
      tick();
      n++;
    end
    check("idle_reached", 32'(n < 50), 32'd1);
  endtask

  // Monitor: pops one expected transaction the cycle after each observed grant.
  logic [3:0] saved_gnt = 4'b0000;
  bit         pend_chk  = 1'b0;
  always @(negedge clk) begin : mon
    exp_t       e;
    logic [3:0] g_exp;
    logic [7:0] nq;
    int         gidx;
    if (!mon_en) begin
      pend_chk = 1'b0;
    end else begin
      if (pend_chk) begin
        check("sb_depth", sb.size(), 32'd1);
        if (sb.size() > 0) begin
          e  = sb.pop_front();
          nq = ~e.d;
          check("txn_gnt", saved_gnt, e.g);
          check("txn_q", q, e.d);
          check("txn_qbar", qbar, nq);
          check("txn_owner", owner, e.o);
          $display("[TB] txn cycle %0d gnt=%b q=0x%02h owner=%0d", cyc, saved_gnt, q, owner);
        end
      end
      pend_chk  = (gnt != 4'b0000);
      saved_gnt = gnt;
      if (gnt != 4'b0000) begin
        gidx = -1;
        for (int i = 0; i < NREQ; i++) if (gnt[i]) gidx = i;
        glog.push_back(gidx);
        gcyc.push_back(cyc);
      end
      g_exp = (m_cap_at == cyc + 1) ? 4'(1 << m_cap_idx) : 4'b0000;
      nq    = ~m_q;
      check("gnt", gnt, g_exp);
      check("q", q, m_q);
      check("qbar", qbar, nq);
      check("owner", owner, m_owner);
      check("busy", busy, 32'(cyc < m_free - 1));
      busy_cycles += busy;
      z_ghist = {z_ghist[30:0], zgnt[0]};
      z_bhist = {z_bhist[30:0], zbusy};
    end
  end

  initial begin
    int base;
    int b0;
    int n;
    req  = '0;
    din  = '0;
    clr  = 1'b0;
    zreq = '0;
    zdin = '0;
    zclr = 1'b0;
    rst  = 1'b0;
    model_reset();
    repeat (2) tick();
    check("por_gnt", gnt, 32'h0);
    check("por_q", q, 32'h00);
    check("por_qbar", qbar, 32'hFF);
    check("por_busy", busy, 32'h0);
    rst    = 1'b1;
    mon_en = 1'b1;
    tick();

    // Single request from requester 1.
    b0        = busy_cycles;
    din[15:8] = 8'hA5;
    req       = 4'b0010;
    tick();
    check("single_gnt", gnt, 32'b0010);
    req = 4'b0000;
    tick();
    check("single_gnt_done", gnt, 32'b0000);
    check("single_q", q, 32'hA5);
    check("single_qbar", qbar, 32'h5A);
    check("single_owner", owner, 32'd1);
    repeat (3) tick();
    check("single_busy_cycles", busy_cycles - b0, 32'd3);

    // Asynchronous reset in the middle of a HOLD window.
    din = 32'h8C6B4A29;
    req = 4'b1111;
    n   = 0;
    while (m_cap_at != cyc + 1 && n < 20) begin
      tick();
      n++;
    end
    check("rst_grant_seen", 32'(n < 20), 32'd1);
    tick();
    tick();
    check("rst_pre_busy", busy, 32'd1);
    #2;
    mon_en = 1'b0;
    rst    = 1'b0;
    #1;
    check("rst_gnt", gnt, 32'h0);
    check("rst_q", q, 32'h00);
    check("rst_qbar", qbar, 32'hFF);
    check("rst_owner", owner, 32'h0);
    check("rst_busy", busy, 32'h0);
    model_reset();
    repeat (2) tick();
    rst    = 1'b1;
    mon_en = 1'b1;
    base   = glog.size();

    // Fairness with all four requesting continuously.
    repeat (24) tick();
    check("fair_count", glog.size() - base, 32'd6);
    if (glog.size() - base >= 6) begin
      for (int i = 0; i < 6; i++) begin
        check("fair_order", glog[base + i], i % NREQ);
        if (i > 0) check("fair_spacing", gcyc[base + i] - gcyc[base + i - 1], 32'd4);
      end
    end
    req = 4'b0000;
    wait_idle();

    // Clear pulse during HOLD while requester 2 waits.
    din[7:0] = 8'h11;
    req      = 4'b0001;
    tick();
    check("cwb_gnt0", gnt, 32'b0001);
    din[23:16] = 8'hC3;
    req        = 4'b0100;
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
    check("cwb_q_held", q, 32'h11);
    tick();
    check("cwb_q_cleared", q, 32'h00);
    check("cwb_qbar_cleared", qbar, 32'hFF);
    check("cwb_no_gnt", gnt, 32'b0000);
    tick();
    check("cwb_gnt2", gnt, 32'b0100);
    req = 4'b0000;
    tick();
    check("cwb_q2", q, 32'hC3);
    check("cwb_owner2", owner, 32'd2);
    wait_idle();

    // clr and req together in IDLE, then the winner withdraws during CAPTURE.
    din[31:24] = 8'h77;
    req        = 4'b1000;
    clr        = 1'b1;
    tick();
    clr = 1'b0;
    check("same_no_gnt", gnt, 32'b0000);
    check("same_q_cleared", q, 32'h00);
    tick();
    check("same_gnt3", gnt, 32'b1000);
    req        = 4'b0000;
    din[31:24] = 8'h99;
    tick();
    check("wd_q", q, 32'h99);
    check("wd_qbar", qbar, 32'h66);
    check("wd_owner", owner, 32'd3);
    wait_idle();

    // Random traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      int w;
      w   = -1;
      clr = ($urandom_range(0, 11) == 0);
      if (m_cap_at == cyc + 1) begin
        w = m_cap_idx;
        if ($urandom_range(0, 3) != 0) begin
          req[w]         = 1'b0;
          din[w*8 +: 8]  = 8'($urandom);
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i] && $urandom_range(0, 5) == 0) begin
          din[i*8 +: 8] = 8'($urandom);
          req[i]        = 1'b1;
        end else if (req[i] && i != w && $urandom_range(0, 29) == 0) begin
          req[i] = 1'b0;
        end
      end
      tick();
    end
    req = 4'b0000;
    clr = 1'b0;
    wait_idle();
    repeat (3) tick();
    check("sb_drain", sb.size(), 32'd0);

    // HOLD=0 instance with requester 0 held high.
    zdin = 32'h0000005A;
    zreq = 4'b0001;
    repeat (20) tick();
    check("h0_gnt_pattern", z_ghist[19:0], 32'hAAAAA);
    check("h0_busy_pattern", z_bhist[19:0], 32'hAAAAA);
    check("h0_q", zq, 32'h5A);
    check("h0_qbar", zqbar, 32'hA5);
    check("h0_owner", zowner, 32'd0);
    zreq = 4'b0000;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
